// File: rtl/datapath_ctrl_if.sv
// Bundles the command handshake and the datapath control/status wires
// between the controller and the bit/shift datapath.
interface datapath_ctrl_if;
    logic       start;
    logic [1:0] mode;
    logic       b;
    logic [2:0] s;
    logic       s_en;
    logic       s_sub;
    logic       s_zero;
    logic [1:0] s_step;
    logic       y_en;
    logic       y_upd;
    logic [1:0] y_select_next;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] idx;

    // Controller side: takes commands and datapath status, drives controls.
    modport slave (
        input  start, mode, b, s,
        output s_en, s_sub, s_zero, s_step, y_en, y_upd, y_select_next,
        output busy, done, found, idx
    );

    // Requester/datapath side: the mirror image of the controller.
    modport master (
        output start, mode, b, s,
        input  s_en, s_sub, s_zero, s_step, y_en, y_upd, y_select_next,
        input  busy, done, found, idx
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Controller for a small y/s datapath: finds the MSB or LSB set bit of y,
// increments y, or accumulates 1..7 into y. Status outputs are registered;
// datapath controls depend on the current state and, in SCAN, on b and s.
module datapath_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    datapath_ctrl_if.slave         bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        INC,
        ACC,
        DONE
    } state_t;

    localparam logic [1:0] MODE_FIND_MSB = 2'd0;
    localparam logic [1:0] MODE_FIND_LSB = 2'd1;
    localparam logic [1:0] MODE_INC      = 2'd2;
    localparam logic [1:0] MODE_ACC      = 2'd3;

    state_t     state_q;
    logic [1:0] mode_q;
    logic       busy_q;
    logic       done_q;
    logic       found_q;
    logic [2:0] idx_q;
    logic [2:0] scanEnd_d;
    logic       scanHit_d;
    logic       scanStop_d;

    // The scan finishes on a set bit or when s reaches the last index for the direction.
    always_comb begin
        scanEnd_d  = (mode_q == MODE_FIND_MSB) ? 3'd0 : 3'd7;
        scanHit_d  = bus.b;
        scanStop_d = bus.b || (bus.s == scanEnd_d);
    end

    // State sequencing plus registered busy/done/found/idx, computed for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_FIND_MSB;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        found_q <= 1'b0;
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    case (mode_q)
                        MODE_INC: state_q <= INC;
                        MODE_ACC: state_q <= ACC;
                        default:  state_q <= SCAN;
                    endcase
                end
                SCAN: begin
                    if (scanStop_d) begin
                        found_q <= scanHit_d;
                        idx_q   <= scanHit_d ? bus.s : 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                INC: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                ACC: begin
                    if (bus.s == 3'd7) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Datapath controls: zero unless the current state needs them; SCAN reacts to b and s in-cycle.
    always_comb begin
        bus.s_en          = 1'b0;
        bus.s_sub         = 1'b0;
        bus.s_zero        = 1'b0;
        bus.s_step        = 2'd0;
        bus.y_en          = 1'b0;
        bus.y_upd         = 1'b0;
        bus.y_select_next = 2'd0;
        case (state_q)
            LOAD: begin
                bus.y_en   = 1'b1;
                bus.s_en   = 1'b1;
                bus.s_zero = 1'b1;
                if (mode_q == MODE_FIND_MSB) begin
                    bus.s_sub  = 1'b1;
                    bus.s_step = 2'd1;
                end else if (mode_q == MODE_ACC) begin
                    bus.s_step = 2'd1;
                end
            end
            SCAN: begin
                if (!scanStop_d) begin
                    bus.s_en   = 1'b1;
                    bus.s_step = 2'd1;
                    bus.s_sub  = (mode_q == MODE_FIND_MSB);
                end
            end
            INC: begin
                bus.y_en          = 1'b1;
                bus.y_upd         = 1'b1;
                bus.y_select_next = 2'd3;
            end
            ACC: begin
                bus.y_en          = 1'b1;
                bus.y_upd         = 1'b1;
                bus.y_select_next = 2'd1;
                bus.s_en          = 1'b1;
                bus.s_step        = 2'd1;
            end
            default: begin
            end
        endcase
    end

    // Status outputs come straight from their registers.
    always_comb begin
        bus.busy  = busy_q;
        bus.done  = done_q;
        bus.found = found_q;
        bus.idx   = idx_q;
    end

    // MODE_FIND_LSB is only named for readability of the mode map.
    logic unusedMode;
    assign unusedMode = (mode_q == MODE_FIND_LSB);

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural y/s datapath closes the loop, a
// reference model predicts each command's outcome from x and mode, and a
// monitor compares against those predictions whenever done pulses.
module tb_datapath_ctrl;

    logic clk;
    logic rst;
    logic [7:0] x;
    logic [7:0] yReg;
    logic [2:0] sReg;
    int cyc;
    int compared;
    int mismatched;
    bit donePending;

    typedef struct {
        logic       found;
        logic [2:0] idx;
        int         lat;
        logic [7:0] y;
        logic [2:0] s;
        int         startCyc;
    } expT;

    expT expQ[$];
    expT monE;

    datapath_ctrl_if bus ();

    datapath_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time commands.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: s steps up or down (optionally from zero), y loads x or updates.
    always @(posedge clk) begin
        if (rst) begin
            yReg <= 8'd0;
            sReg <= 3'd0;
        end else begin
            if (bus.s_en)
                sReg <= bus.s_sub ? ((bus.s_zero ? 3'd0 : sReg) - 3'(bus.s_step))
                                  : ((bus.s_zero ? 3'd0 : sReg) + 3'(bus.s_step));
            if (bus.y_en) begin
                if (!bus.y_upd) yReg <= x;
                else case (bus.y_select_next)
                    2'd1: yReg <= yReg + 8'(sReg);
                    2'd2: yReg <= yReg - 8'(sReg);
                    2'd3: yReg <= yReg + 8'd1;
                    default: yReg <= yReg;
                endcase
            end
        end
    end

    assign bus.b = yReg[sReg];
    assign bus.s = sReg;

    // One comparison; reports and counts any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference outcome of one command, from the command semantics alone.
    function automatic expT model(input logic [1:0] m, input logic [7:0] xv);
        expT e;
        e.found = 1'b0; e.idx = 3'd0; e.y = xv; e.s = 3'd0; e.lat = 10; e.startCyc = 0;
        case (m)
            2'd0: begin
                for (int i = 7; i >= 0; i--)
                    if (!e.found && xv[i]) begin e.found = 1'b1; e.idx = 3'(i); end
                e.s   = e.found ? e.idx : 3'd0;
                e.lat = e.found ? 3 + (7 - int'(e.idx)) : 10;
            end
            2'd1: begin
                for (int i = 0; i < 8; i++)
                    if (!e.found && xv[i]) begin e.found = 1'b1; e.idx = 3'(i); end
                e.s   = e.found ? e.idx : 3'd7;
                e.lat = e.found ? 3 + int'(e.idx) : 10;
            end
            2'd2: begin e.y = xv + 8'd1;  e.lat = 3; end
            default: begin e.y = xv + 8'd28; e.lat = 9; end
        endcase
        return e;
    endfunction

    // Issues one command, optionally pokes start mid-command, waits for the monitor to retire it.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] xv, input bit pokeStart);
        expT e;
        int waitCount;
        @(negedge clk);
        checkOutput("idleBusy", bus.busy, 0);
        checkOutput("idleYEn", bus.y_en, 0);
        x = xv;
        bus.mode = m;
        bus.start = 1'b1;
        e = model(m, xv);
        e.startCyc = cyc + 1;
        expQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("loadBusy", bus.busy, 1);
        checkOutput("loadYEn", bus.y_en, 1);
        checkOutput("loadFoundClr", bus.found, 0);
        if (pokeStart) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.mode = 2'd0;
            @(negedge clk);
            bus.start = 1'b0;
        end
        waitCount = 0;
        while (expQ.size() != 0 && waitCount < 30) begin
            @(negedge clk);
            waitCount++;
        end
        if (expQ.size() != 0) begin
            checkOutput("doneTimeout", expQ.size(), 0);
            expQ.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("heldFound", bus.found, e.found);
        checkOutput("heldIdx", bus.idx, e.idx);
    endtask

    // Monitor: retires the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (donePending) begin
                checkOutput("doneWidth", bus.done, 0);
                donePending = 1'b0;
            end
            if (bus.done === 1'b1) begin
                donePending = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("found", bus.found, monE.found);
                    checkOutput("idx", bus.idx, monE.idx);
                    checkOutput("latency", cyc - monE.startCyc + 1, monE.lat);
                    checkOutput("yFinal", yReg, monE.y);
                    checkOutput("sFinal", sReg, monE.s);
                    checkOutput("doneBusy", bus.busy, 0);
                end
            end
        end
    end

    // Main sequence: reset, directed cases, mid-scan reset, then random commands.
    initial begin
        logic [7:0] rx;
        cyc = 0; compared = 0; mismatched = 0; donePending = 1'b0;
        rst = 1'b1; x = 8'd0; bus.start = 1'b0; bus.mode = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.done, 0);
        checkOutput("rstFound", bus.found, 0);
        checkOutput("rstIdx", bus.idx, 0);
        checkOutput("rstSEn", bus.s_en, 0);
        rst = 1'b0;

        applyStimulus(2'd0, 8'h28, 1'b0);
        applyStimulus(2'd1, 8'h28, 1'b0);
        applyStimulus(2'd0, 8'h00, 1'b0);
        applyStimulus(2'd3, 8'hF0, 1'b0);
        applyStimulus(2'd2, 8'hFF, 1'b1);
        applyStimulus(2'd1, 8'h00, 1'b0);

        @(negedge clk);
        x = 8'h00; bus.mode = 2'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstBusy", bus.busy, 0);
        checkOutput("midRstDone", bus.done, 0);
        checkOutput("midRstFound", bus.found, 0);
        checkOutput("midRstIdx", bus.idx, 0);
        checkOutput("midRstSEn", bus.s_en, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("postRstBusy", bus.busy, 0);
        applyStimulus(2'd0, 8'h28, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rx = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rx = 8'd0;
            applyStimulus(2'($urandom_range(0, 3)), rx, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
